// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: synchronizes codec bclk/lrclk/sdata into the system clock domain and
// presents each left/right frame on a valid/ready hold port. Short-word checking: I2S_RX_FRAME_CHECK_EN.
module i2s_adc_receiver #(
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ac_bclk,
   input  logic                  ac_lrclk,
   input  logic                  ac_adc_sdata,
   output logic [DATA_WIDTH-1:0] out_left,
   output logic [DATA_WIDTH-1:0] out_right,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun,
   output logic                  frame_err
);

   localparam logic [5:0] WordLen = 6'(DATA_WIDTH);

   typedef enum logic [1:0] {StHunt, StLeft, StRight} state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  bclk_sync, lr_sync, sd_sync;
   logic                    bclk_s, lr_s, sd_s;
   logic                    bclk_prev_q, lr_prev_q;
   logic                    rise, lr_change, short_word;
   logic [5:0]              bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic [DATA_WIDTH-1:0]   load_right;
   logic                    load;
   logic                    right_ok;
   logic                    deliver_short;

   assign bclk_s    = bclk_sync[SYNC_STAGES-1];
   assign lr_s      = lr_sync[SYNC_STAGES-1];
   assign sd_s      = sd_sync[SYNC_STAGES-1];
   assign rise      = bclk_s & ~bclk_prev_q;
   assign lr_change = rise & (lr_s ^ lr_prev_q);

`ifdef I2S_RX_FRAME_CHECK_EN
   logic frame_bad_q, frame_bad_d;
   logic frame_err_q;

   // A short left word poisons the frame until the next left word starts.
   always_comb begin
      frame_bad_d = frame_bad_q;
      if (lr_change) begin
         if (state_q == StLeft) frame_bad_d = short_word;
         if (state_d == StLeft) frame_bad_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_bad_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_bad_q <= frame_bad_d;
         frame_err_q <= short_word;
      end
   end

   assign right_ok      = ~frame_bad_q;
   assign deliver_short = 1'b0;
   assign frame_err     = frame_err_q;
`else
   assign right_ok      = 1'b1;
   assign deliver_short = 1'b1;
   assign frame_err     = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      hold_d     = hold_q;
      load       = 1'b0;
      load_right = shift_q;
      short_word = 1'b0;
      if (rise) begin
         if (lr_change) begin
            // The bit sampled with the lrclk edge is the previous word's LSB slot.
            short_word = (state_q != StHunt) && (bit_cnt_q < WordLen);
            bit_cnt_d  = '0;
            shift_d    = '0;
            case (state_q)
               StHunt:  if (!lr_s) state_d = StLeft;
               StLeft:  if (lr_s) state_d = StRight;
               StRight: if (!lr_s) state_d = StLeft;
               default: state_d = StHunt;
            endcase
            if (deliver_short && short_word && state_q == StLeft) hold_d = shift_q;
            if (deliver_short && short_word && state_q == StRight) load = 1'b1;
         end else if (bit_cnt_q < WordLen) begin
            shift_d   = shift_q | (DATA_WIDTH'(sd_s) << (WordLen - 6'd1 - bit_cnt_q));
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == WordLen - 6'd1) begin
               if (state_q == StLeft) hold_d = shift_d;
               if (state_q == StRight) begin
                  load       = right_ok;
                  load_right = shift_d;
               end
            end
         end else if (bit_cnt_q != 6'h3f) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bclk_sync   <= '0;
         lr_sync     <= '0;
         sd_sync     <= '0;
         bclk_prev_q <= 1'b0;
         lr_prev_q   <= 1'b1;
         state_q     <= StHunt;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
      end else begin
         bclk_sync   <= SYNC_STAGES'({bclk_sync, ac_bclk});
         lr_sync     <= SYNC_STAGES'({lr_sync, ac_lrclk});
         sd_sync     <= SYNC_STAGES'({sd_sync, ac_adc_sdata});
         bclk_prev_q <= bclk_s;
         if (rise) lr_prev_q <= lr_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
      end
   end

   // A load in the same cycle as an accept wins: valid stays high with the new frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_left  <= '0;
         out_right <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            out_left  <= hold_q;
            out_right <= load_right;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         overrun <= load & out_valid & ~out_ready;
      end
   end

endmodule

// File: doc/i2s_adc_receiver.md
I2S_ADC_RECEIVER -- requirements
Module: i2s_adc_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, the audio sample width in bits, MSB-first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer flop count on each codec input.
REQ-003 SHALL have port clock, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous and active-high.
REQ-005 SHALL have port ac_bclk, input, 1, the codec bit clock, asynchronous to clock.
REQ-006 SHALL have port ac_lrclk, input, 1, the codec word select: 0 = left, 1 = right.
REQ-007 SHALL have port ac_adc_sdata, input, 1, the codec ADC serial data.
REQ-008 SHALL have port out_left, output, DATA_WIDTH, the left sample of the held frame.
REQ-009 SHALL have port out_right, output, DATA_WIDTH, the right sample of the held frame.
REQ-010 SHALL have port out_valid, output, 1, which is high while a frame is held.
REQ-011 SHALL have port out_ready, input, 1, the consumer accept signal.
REQ-012 SHALL have port overrun, output, 1, a one-cycle pulse when an unaccepted frame is overwritten.
REQ-013 SHALL have port frame_err, output, 1, a one-cycle pulse for a short half-frame.

Function
REQ-014 SHALL pass ac_bclk, ac_lrclk and ac_adc_sdata through SYNC_STAGES flops each; every decision below uses only the synchronized copies.
REQ-015 SHALL detect a bclk rise as synchronized bclk = 1 while its previous-cycle value = 0, and SHALL sample lrclk and sdata only in that cycle.
REQ-016 SHALL keep a 3-state FSM with states HUNT, LEFT and RIGHT.
REQ-017 SHALL treat an lrclk change as sampled lrclk differing from the lrclk sampled at the previous bclk rise.
REQ-018 SHALL use these FSM transitions on an lrclk change: HUNT moves to LEFT only on 1->0; LEFT moves to RIGHT on 0->1; RIGHT moves to LEFT on 1->0.
REQ-019 SHALL, in HUNT, discard all data and emit no output.
REQ-020 SHALL, on an lrclk change, treat the sdata bit sampled at that same rise as the previous word's LSB slot and not capture it; a 6-bit bit_cnt clears to 0 and the shift register clears.
REQ-021 SHALL, at each later rise with bit_cnt < DATA_WIDTH, write sdata to bit position DATA_WIDTH-1-bit_cnt and increment bit_cnt.
REQ-022 SHALL ignore bits once bit_cnt >= DATA_WIDTH and saturate bit_cnt at 63.
REQ-023 SHALL copy the shift register to an internal left hold register when bit_cnt reaches DATA_WIDTH in LEFT.
REQ-024 SHALL, when bit_cnt reaches DATA_WIDTH in RIGHT, load out_left from the left hold register and out_right from the shift register, and set out_valid, all on the clock edge after that bclk-rise cycle.
REQ-025 SHALL keep out_valid high and the data stable until a cycle with out_valid = 1 and out_ready = 1, after which out_valid clears on the next edge.
REQ-026 SHALL, when a new frame loads while out_valid = 1 and out_ready = 0, replace the data, keep out_valid high and pulse overrun.
REQ-027 SHALL, when a new frame loads in the same cycle as an accept (out_ready = 1), load the new data, keep out_valid = 1 and not pulse overrun.
REQ-028 SHALL treat an lrclk change while in LEFT or RIGHT with bit_cnt < DATA_WIDTH as a short half-frame, handled as specified under Configuration.

Reset
REQ-029 SHALL, while reset is asserted, set the FSM to HUNT; out_left, out_right, the hold and shift registers, bit_cnt, out_valid, overrun, frame_err and all synchronizer flops to 0; and the previous-lrclk register to 1.
REQ-030 SHALL, on reset asserted mid-word or mid-handshake, drop the frame immediately with no overrun and no frame_err pulse.

Configuration
REQ-031 SHALL, when macro I2S_RX_FRAME_CHECK_EN is defined: on a short half-frame pulse frame_err for one cycle; a short left word marks the frame bad and suppresses the next RIGHT completion; a short right word produces no out_valid.
REQ-032 SHALL, when I2S_RX_FRAME_CHECK_EN is undefined: tie frame_err to 0, deliver short words with their missing LSBs as 0, and treat a short right word as complete at the lrclk change.

Verification
REQ-033 SHALL verify that bclk at clock/32, DATA_WIDTH = 24, left 0x123456 and right 0xABCDEF, out_ready = 1 produce out_valid with exactly those values, one pulse per frame.
REQ-034 SHALL verify that 3 frames 0x000001/0x000002, 0x000003/0x000004, 0x000005/0x000006 sent with out_ready = 0 leave the outputs at 0x000005/0x000006 with 2 overrun pulses.
REQ-035 SHALL verify that a stream starting with lrclk = 1 mid-right-word produces no output until the first 1->0 lrclk change, after which the first complete frame is delivered.
REQ-036 SHALL verify that a left word cut to 16 bits gives frame_err = 1 and no out_valid for that frame when the macro is defined, and out_left = 0xXXXX00 (top 16 bits as sent, 8 LSBs 0) and frame_err = 0 when it is undefined.
REQ-037 SHALL verify that reset asserted after the 12th right bit gives out_valid = 0 at once, and that the first frame after release is delivered correctly from HUNT.
REQ-038 SHALL verify that out_ready asserted in the same cycle as a new frame load gives out_valid held at 1, the new data, and overrun = 0.
